// File: rtl/cnt_seq_pkg.sv
// Shared definitions for the count_sequencer block.
//   state_t : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   clog2() : constant-evaluable ceiling log2, used to size the prescaler
package cnt_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int clog2(input longint value);
    longint one;
    int     r;
    one = 1;
    r   = 0;
    while ((one << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/count_sequencer_tick_gen.sv
// tick_gen: free-running prescaler for the RUN auto-advance rate.
//   Counts 0..PRESCALE-1 while en_i is high and pulses tick_o (combinational)
//   during the cycle it sits at PRESCALE-1; the counter clears on that edge.
// Ports:
//   clk_i   in  system clock
//   rst_i   in  synchronous reset, active-high
//   clr_i   in  clear the count (wins over en_i, suppresses tick_o)
//   en_i    in  count enable
//   tick_o  out one-cycle advance request
module tick_gen
  import cnt_seq_pkg::*;
#(
  parameter int PRESCALE = 100_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  // PRESCALE=1 would give a zero-width counter; keep one bit that stays at 0.
  localparam int CW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: control FSM around the board's event counter.
//   Manual step, free-run at a prescaled rate, load from switches, and
//   stop (DONE) or wrap at a programmable limit.
// Optional feature macro: CNT_SEQ_DOWN_EN adds dir_i (1 = count down,
//   terminal count 0, wrap reloads limit_i).
// Ports:
//   clk_i      in   system clock
//   rst_i      in   synchronous reset, active-high
//   step_i     in   1-cycle pulse, advance once (IDLE only)
//   run_i      in   1-cycle pulse, toggle IDLE<->RUN
//   load_i     in   1-cycle pulse, count <= data_i, back to IDLE
//   data_i     in   load value
//   limit_i    in   terminal count (up) / wrap reload value (down)
//   wrap_i     in   1 wrap at terminal count, 0 stop in DONE
//   dir_i      in   0 up / 1 down (CNT_SEQ_DOWN_EN only)
//   count_o    out  counter value
//   running_o  out  high in RUN
//   tick_o     out  pulse on the edge where count_o advances
//   done_o     out  high in DONE
module count_sequencer
  import cnt_seq_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 100_000_000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             step_i,
  input  logic             run_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic             wrap_i,
`ifdef CNT_SEQ_DOWN_EN
  input  logic             dir_i,
`endif
  output logic [WIDTH-1:0] count_o,
  output logic             running_o,
  output logic             tick_o,
  output logic             done_o
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             down;
  logic             presc_tick, presc_clr, presc_en;
  logic             at_term;
  logic [WIDTH-1:0] adv_val;

`ifdef CNT_SEQ_DOWN_EN
  assign down = dir_i;
`else
  assign down = 1'b0;
`endif

  // The prescaler only runs in RUN; any load or run toggle restarts it so
  // the first auto-advance after entering RUN is a full PRESCALE period away.
  assign presc_en  = (state_q == ST_RUN);
  assign presc_clr = load_i || run_i || (state_q != ST_RUN);

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (presc_clr),
    .en_i   (presc_en),
    .tick_o (presc_tick)
  );

  // Value an advance would produce; limit_i/wrap_i are sampled live.
  always_comb begin
    at_term = down ? (count_q == '0) : (count_q == limit_i);
    adv_val = count_q;
    if (at_term) begin
      adv_val = down ? limit_i : '0;
    end else begin
      adv_val = down ? (count_q - 1'b1) : (count_q + 1'b1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    logic do_adv;
    state_d = state_q;
    count_d = count_q;
    tick_d  = 1'b0;
    do_adv  = 1'b0;

    if (load_i) begin
      count_d = data_i;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run_i)       state_d = ST_RUN;
          else if (step_i) do_adv  = 1'b1;
        end
        ST_RUN: begin
          if (run_i)           state_d = ST_IDLE;
          else if (presc_tick) do_adv  = 1'b1;
        end
        default: ;
      endcase
    end

    // At the terminal count without wrap the count holds and the FSM parks.
    if (do_adv) begin
      if (at_term && !wrap_i) begin
        state_d = ST_DONE;
      end else begin
        count_d = adv_val;
        tick_d  = 1'b1;
      end
    end
  end

  assign count_o   = count_q;
  assign tick_o    = tick_q;
  assign running_o = (state_q == ST_RUN);
  assign done_o    = (state_q == ST_DONE);

endmodule

// File: tb/tb_count_sequencer.sv
// Testbench for count_sequencer (WIDTH=8, PRESCALE=4): directed scenarios
// followed by randomized pulses, all compared against a behavioural model.
module tb_count_sequencer;

  localparam int W = 8;
  localparam int P = 4;

  logic         clk;
  logic         rst_i, step_i, run_i, load_i, wrap_i, dir_i;
  logic [W-1:0] data_i, limit_i;
  logic [W-1:0] count_o;
  logic         running_o, tick_o, done_o;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model: 0 idle, 1 run, 2 done
  int m_state, m_count, m_presc, m_tick;

  count_sequencer #(
    .WIDTH(W),
    .PRESCALE(P)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .step_i    (step_i),
    .run_i     (run_i),
    .load_i    (load_i),
    .data_i    (data_i),
    .limit_i   (limit_i),
    .wrap_i    (wrap_i),
`ifdef CNT_SEQ_DOWN_EN
    .dir_i     (dir_i),
`endif
    .count_o   (count_o),
    .running_o (running_o),
    .tick_o    (tick_o),
    .done_o    (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_advance();
    bit dn;
    dn = 1'b0;
`ifdef CNT_SEQ_DOWN_EN
    dn = dir_i;
`endif
    if (!dn) begin
      if (m_count != int'(limit_i)) begin
        m_count = (m_count + 1) % 256;
        m_tick  = 1;
      end else if (wrap_i) begin
        m_count = 0;
        m_tick  = 1;
      end else begin
        m_state = 2;
      end
    end else begin
      if (m_count != 0) begin
        m_count = m_count - 1;
        m_tick  = 1;
      end else if (wrap_i) begin
        m_count = int'(limit_i);
        m_tick  = 1;
      end else begin
        m_state = 2;
      end
    end
  endtask

  task automatic model_edge();
    m_tick = 0;
    if (rst_i) begin
      m_state = 0; m_count = 0; m_presc = 0;
    end else if (load_i) begin
      m_count = int'(data_i); m_state = 0; m_presc = 0;
    end else if (m_state == 0) begin
      if (run_i) begin
        m_state = 1; m_presc = 0;
      end else if (step_i) begin
        model_advance();
      end
    end else if (m_state == 1) begin
      if (run_i) begin
        m_state = 0; m_presc = 0;
      end else if (m_presc == P - 1) begin
        m_presc = 0;
        model_advance();
      end else begin
        m_presc++;
      end
    end
  endtask

  // One clock: drive pulses, let the edge happen, compare on the falling edge.
  task automatic cyc(input bit r, input bit s, input bit rn, input bit ld, input string tag);
    rst_i = r; step_i = s; run_i = rn; load_i = ld;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    rst_i = 1'b0; step_i = 1'b0; run_i = 1'b0; load_i = 1'b0;
    check({tag, ".count"},   32'(count_o),   32'(m_count));
    check({tag, ".running"}, 32'(running_o), 32'(m_state == 1));
    check({tag, ".tick"},    32'(tick_o),    32'(m_tick));
    check({tag, ".done"},    32'(done_o),    32'(m_state == 2));
  endtask

  initial begin
    int ticks;
    rst_i = 0; step_i = 0; run_i = 0; load_i = 0;
    wrap_i = 0; dir_i = 0; data_i = '0; limit_i = 8'hFF;
    m_state = 0; m_count = 0; m_presc = 0; m_tick = 0;
    @(negedge clk);
    cyc(1, 0, 0, 0, "init_rst");

    // 1: reset while running
    data_i = 8'h23;
    cyc(0, 0, 0, 1, "t1_load");
    cyc(0, 0, 1, 0, "t1_run");
    cyc(0, 0, 0, 0, "t1_idle");
    check("t1_running_pre", 32'(running_o), 32'd1);
    cyc(1, 0, 0, 0, "t1_rst");
    check("t1_count", 32'(count_o), 32'h00);
    check("t1_running", 32'(running_o), 32'd0);
    check("t1_done", 32'(done_o), 32'd0);
    check("t1_tick", 32'(tick_o), 32'd0);

    // 2: load then three steps; load beats run
    data_i = 8'h0E; limit_i = 8'hFF;
    cyc(0, 0, 0, 1, "t2_load");
    ticks = 0;
    repeat (3) begin
      cyc(0, 1, 0, 0, "t2_step"); ticks += int'(tick_o);
      cyc(0, 0, 0, 0, "t2_gap");  ticks += int'(tick_o);
    end
    check("t2_count", 32'(count_o), 32'h11);
    check("t2_ticks", 32'(ticks), 32'd3);
    data_i = 8'h40;
    cyc(0, 0, 1, 1, "t2_load_run");
    check("t2_load_run_count", 32'(count_o), 32'h40);
    check("t2_load_run_running", 32'(running_o), 32'd0);

    // 3: free-run every P cycles
    data_i = 8'h00;
    cyc(0, 0, 0, 1, "t3_load");
    cyc(0, 0, 1, 0, "t3_run");
    repeat (20) cyc(0, 0, 0, 0, "t3_free");
    check("t3_count20", 32'(count_o), 32'h05);
    cyc(0, 0, 1, 0, "t3_stop");
    check("t3_running", 32'(running_o), 32'd0);
    repeat (8) cyc(0, 0, 0, 0, "t3_frozen");
    check("t3_frozen_count", 32'(count_o), 32'h05);

    // 4: stop at limit
    limit_i = 8'h05; wrap_i = 1'b0; data_i = 8'h03;
    cyc(0, 0, 0, 1, "t4_load");
    cyc(0, 0, 1, 0, "t4_run");
    repeat (12) cyc(0, 0, 0, 0, "t4_free");
    check("t4_done", 32'(done_o), 32'd1);
    check("t4_count", 32'(count_o), 32'h05);
    check("t4_running", 32'(running_o), 32'd0);
    cyc(0, 0, 1, 0, "t4_run_ign");
    cyc(0, 1, 0, 0, "t4_step_ign");
    cyc(0, 0, 0, 0, "t4_hold");
    check("t4_still_done", 32'(done_o), 32'd1);
    data_i = 8'h00;
    cyc(0, 0, 0, 1, "t4_exit");
    check("t4_exit_done", 32'(done_o), 32'd0);

    // 5: wrap at limit, and roll over from above the limit
    wrap_i = 1'b1; data_i = 8'h05;
    cyc(0, 0, 0, 1, "t5_load");
    cyc(0, 1, 0, 0, "t5_wrap");
    check("t5_wrap_count", 32'(count_o), 32'h00);
    check("t5_wrap_tick", 32'(tick_o), 32'd1);
    data_i = 8'hFA;
    cyc(0, 0, 0, 1, "t5_load_fa");
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 0, 0, "t5_roll");
      check("t5_roll_count", 32'(count_o), 32'((8'hFB + i) & 8'hFF));
    end

`ifdef CNT_SEQ_DOWN_EN
    // 6: down count
    dir_i = 1'b1; limit_i = 8'h09; wrap_i = 1'b1; data_i = 8'h01;
    cyc(0, 0, 0, 1, "t6_load");
    cyc(0, 1, 0, 0, "t6_dn0");
    check("t6_zero", 32'(count_o), 32'h00);
    cyc(0, 1, 0, 0, "t6_dnwrap");
    check("t6_wrap", 32'(count_o), 32'h09);
    wrap_i = 1'b0;
    cyc(0, 0, 0, 1, "t6_reload");
    cyc(0, 1, 0, 0, "t6_dn0b");
    cyc(0, 1, 0, 0, "t6_stop");
    check("t6_done", 32'(done_o), 32'd1);
    check("t6_done_count", 32'(count_o), 32'h00);
    dir_i = 1'b0;
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit r, s, rn, ld;
      r  = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 4) == 0);
      rn = ($urandom_range(0, 24) == 0);
      ld = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0)
        limit_i = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      if ($urandom_range(0, 29) == 0) wrap_i = 1'($urandom);
      data_i = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
`ifdef CNT_SEQ_DOWN_EN
      if ($urandom_range(0, 59) == 0) dir_i = 1'($urandom);
`endif
      cyc(r, s, rn, ld, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
